// File: rtl/mux_arb_defs_pkg.sv
// mux_arb_defs: arbitration mode codes and select-width helper shared by the arbiters
package mux_arb_defs;
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR = 1;
  function automatic int selw(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational picker, first requester at or after start (rr_en) or from index 0
module rr_pick
  import mux_arb_defs::*;
#(
  parameter int M = 4,
  localparam int SELW = selw(M)
) (
  input  logic [M-1:0]    req,
  input  logic [SELW-1:0] start,
  input  logic            rr_en,
  output logic [SELW-1:0] gnt_idx,
  output logic            any
);
  logic [SELW-1:0] base;
  function automatic logic [SELW-1:0] wrap(input logic [SELW-1:0] b, input int i);
    int s;
    s = int'(b) + i;
    return SELW'(s >= M ? s - M : s);
  endfunction
  assign base = rr_en ? start : '0;
  assign any = |req;
  // Scan from the farthest offset down so the nearest requester overwrites the rest.
  always_comb begin
    gnt_idx = '0;
    for (int i = M - 1; i >= 0; i--) gnt_idx = req[wrap(base, i)] ? wrap(base, i) : gnt_idx;
  end
endmodule

// File: rtl/mux_arb_m_n.sv
// mux_arb_m_n: registered M-channel N-bit mux with per-channel valid/ready and built-in arbitration
module mux_arb_m_n
  import mux_arb_defs::*;
#(
  parameter int N = 8,
  parameter int M = 4,
  parameter int RR = ARB_RR,
  localparam int SELW = selw(M)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [M*N-1:0]  in_data,
  input  logic [M-1:0]    in_valid,
  output logic [M-1:0]    in_ready,
  output logic [N-1:0]    out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SELW-1:0] out_sel
);
  logic [SELW-1:0] ptr;
  logic [SELW-1:0] gnt;
  logic            any;
  logic            load;
  rr_pick #(.M(M)) u_pick (
    .req(in_valid),
    .start(ptr),
    .rr_en(RR != ARB_FIXED),
    .gnt_idx(gnt),
    .any(any)
  );
  assign load = !out_valid || out_ready;
  assign in_ready = (rst_n && load && any) ? M'(1) << gnt : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (load) begin
      out_valid <= any;
      if (any) begin
        out_data <= in_data[gnt*N +: N];
        out_sel  <= gnt;
        if (RR != ARB_FIXED) ptr <= (gnt == SELW'(M - 1)) ? '0 : gnt + SELW'(1);
      end
    end
  end
endmodule

// File: tb/tb_mux_arb_m_n.sv
// tb_mux_arb_m_n: round-robin and fixed-priority instances driven together, scoreboarded against a behavioural model
module tb_mux_arb_m_n;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] in_data;
  logic [3:0]  in_valid;
  logic        out_ready;
  logic [3:0]  rdy [2];
  logic [2:0]  od [2];
  logic        ov [2];
  logic [1:0]  os [2];
  int          vecs = 0;
  int          errs = 0;
  logic [4:0]  q0 [$];
  logic [4:0]  q1 [$];
  logic        m_valid [2];
  logic [2:0]  m_data [2];
  logic [1:0]  m_sel [2];
  int          m_ptr [2];

  always #5 clk = ~clk;

  mux_arb_m_n #(.N(3), .M(4), .RR(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy[0]),
    .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready), .out_sel(os[0])
  );
  mux_arb_m_n #(.N(3), .M(4), .RR(0)) u_fp (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy[1]),
    .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready), .out_sel(os[1])
  );

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s[%s] at %0t: got %0h expected %0h", nm, d == 0 ? "rr" : "fp", $time, act, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] v, input int start);
    for (int i = 0; i < 4; i++) if (v[(start + i) % 4]) return (start + i) % 4;
    return -1;
  endfunction

  task automatic cyc(input logic [3:0] v, input logic r, input int n);
    in_valid = v;
    out_ready = r;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Monitor and reference model: sample mid-cycle, then predict the coming edge.
  initial begin
    logic [4:0] e;
    logic [3:0] er;
    int g;
    logic ld;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!rst_n) begin
          chk("rst_ready", d, rdy[d], 0);
          chk("rst_valid", d, ov[d], 0);
          chk("rst_data", d, od[d], 0);
          chk("rst_sel", d, os[d], 0);
          m_valid[d] = 1'b0;
          m_data[d] = '0;
          m_sel[d] = '0;
          m_ptr[d] = 0;
          if (d == 0) q0.delete(); else q1.delete();
        end else begin
          chk("out_valid", d, ov[d], m_valid[d]);
          if (ov[d] && out_ready) begin
            if ((d == 0 ? q0.size() : q1.size()) == 0) chk("word_unexpected", d, {os[d], od[d]}, 32'hdead);
            else begin
              e = (d == 0) ? q0.pop_front() : q1.pop_front();
              chk("word", d, {os[d], od[d]}, e);
            end
          end else if (!ov[d]) begin
            chk("held_data", d, od[d], m_data[d]);
            chk("held_sel", d, os[d], m_sel[d]);
          end
          g = pick(in_valid, d == 0 ? m_ptr[0] : 0);
          ld = !m_valid[d] || out_ready;
          er = (ld && g >= 0) ? 4'b1 << g : 4'b0;
          chk("in_ready", d, rdy[d], er);
          if (ld) begin
            m_valid[d] = g >= 0;
            if (g >= 0) begin
              m_data[d] = in_data[g*3 +: 3];
              m_sel[d] = 2'(g);
              if (d == 0) begin
                q0.push_back({m_sel[d], m_data[d]});
                m_ptr[0] = (g + 1) % 4;
              end else q1.push_back({m_sel[d], m_data[d]});
            end
          end
        end
      end
    end
  end

  initial begin
    in_valid = '0;
    out_ready = 1'b0;
    in_data = {3'b111, 3'b101, 3'b010, 3'b001};
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    cyc(4'b1111, 1'b1, 5);
    cyc(4'b1111, 1'b0, 3);
    cyc(4'b1111, 1'b1, 3);
    cyc(4'b0100, 1'b1, 4);
    cyc(4'b1110, 1'b1, 4);
    cyc(4'b1100, 1'b1, 2);
    cyc(4'b0000, 1'b1, 2);
    cyc(4'b1111, 1'b0, 2);
    rst_n = 1'b0;
    cyc(4'b1111, 1'b1, 2);
    rst_n = 1'b1;
    cyc(4'b1111, 1'b1, 3);
    repeat (300) begin
      in_data = 12'($urandom);
      cyc(4'($urandom), $urandom_range(0, 3) != 0, 1);
    end
    cyc(4'b0000, 1'b1, 2);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
